// File: rtl/imem_boot_pkg.sv
// Shared definitions for the IMem boot loader.
//   state_t        : loader FSM states
//   *_DEF          : default geometry (32 words of 32 bits, 5-bit word address)
//   BYTES_PER_WORD : bytes packed into one instruction word
package imem_boot_pkg;
  localparam int DEPTH_DEF      = 32;
  localparam int ADDR_W_DEF     = 5;
  localparam int WORD_W_DEF     = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;
endpackage

// File: rtl/imem_boot_loader_packer.sv
// byte_word_packer: assembles little-endian bytes into one instruction word.
//   clk, reset : clock, synchronous active-high reset
//   clear      : drop any partial word and restart at lane 0
//   load       : byte_in is accepted this cycle
//   byte_in    : stream byte
//   word       : assembled word (stable while no byte is loaded)
//   word_full  : the byte loaded this cycle completes the word
module byte_word_packer
  import imem_boot_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);
  logic [1:0]        lane;
  logic [WORD_W-1:0] buffer;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane   <= '0;
      buffer <= '0;
    end else if (load) begin
      // lane 0 carries instr[7:0]
      buffer[{lane, 3'b000} +: 8] <= byte_in;
      lane                        <= lane + 2'd1;
    end
  end

  assign word      = buffer;
  assign word_full = load && (lane == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed byte stream into IMem and holds the core
// in reset until the frame completes with a good checksum.
// Frame: COUNT (N words), 4*N data bytes little-endian, CSUM = XOR of all.
//   clk, reset             : clock, synchronous active-high reset
//   byte_valid/byte_data   : host byte stream
//   byte_ready             : byte accepted when byte_valid & byte_ready
//   reload                 : restart from S_DONE / S_ERROR
//   imem_we/addr/wdata     : IMem write port, one strobe per word
//   core_reset             : core hold-reset, low only after a clean load
//   load_done, load_error  : load status levels
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error
);
  state_t            state, state_next;
  logic [7:0]        count_n;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] word_idx;
  logic [WORD_W-1:0] word;
  logic              word_full;
  logic              xfer;
  logic              restart;
  logic              last_word;

  assign byte_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CSUM);
  assign xfer       = byte_valid && byte_ready;
  assign restart    = reload && ((state == S_DONE) || (state == S_ERROR));
  assign last_word  = (8'(word_idx) == count_n - 8'd1);

  byte_word_packer #(.WORD_W(WORD_W)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (restart),
    .load      (xfer && (state == S_DATA)),
    .byte_in   (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_COUNT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_COUNT: if (xfer) begin
        if (byte_data > 8'(DEPTH))  state_next = S_ERROR;
        else if (byte_data == 8'd0) state_next = S_CSUM;
        else                        state_next = S_DATA;
      end
      S_DATA:  if (word_full) state_next = S_WRITE;
      S_WRITE: state_next = last_word ? S_CSUM : S_DATA;
      S_CSUM:  if (xfer) state_next = (byte_data == csum) ? S_DONE : S_ERROR;
      S_DONE,
      S_ERROR: if (reload) state_next = S_COUNT;
      default: state_next = S_COUNT;
    endcase
  end

  // Counters and running checksum; the CSUM byte itself is compared, not folded in.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count_n  <= '0;
      csum     <= '0;
      word_idx <= '0;
    end else begin
      if (xfer && (state != S_CSUM)) csum    <= csum ^ byte_data;
      if (xfer && (state == S_COUNT)) count_n <= byte_data;
      if (state == S_WRITE)           word_idx <= word_idx + 1'b1;
    end
  end

  assign imem_we    = (state == S_WRITE);
  assign imem_addr  = word_idx;
  assign imem_wdata = word;
  assign core_reset = (state != S_DONE);
  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERROR);
endmodule
